// File: rtl/ledblink_multi_if.sv
// Trigger/mode inputs and q/active outputs of the ledblink_multi indicator stretcher.
// The design side uses the slave modport; whoever drives triggers and reads LEDs uses master.
interface ledblink_multi_if #(
    parameter int unsigned NCH = 4
);
    logic [NCH-1:0]   trigger;
    logic [2*NCH-1:0] mode;
    logic [NCH-1:0]   q;
    logic [NCH-1:0]   active;

    modport master (output trigger, output mode, input q, input active);
    modport slave  (input trigger, input mode, output q, output active);
endinterface

// File: rtl/ledblink_multi.sv
// Multi-channel LED pulse stretcher: stretch / one-shot / blink / off per channel, durations in shared prescaler ticks.
// Optional macro LEDBLINK_MULTI_BLINK_EN adds blink phase counters; without it mode 10 behaves as stretch.
module ledblink_multi #(
    parameter int unsigned     NCH        = 4,
    parameter int unsigned     CNTW       = 16,
    parameter logic [CNTW-1:0] DURATION   = 16'd5000,
    parameter int unsigned     PRESC      = 32'd2000,
    parameter logic [7:0]      BLINK_HALF = 8'd250
) (
    input  logic           clk,
    input  logic           reset_n,
    ledblink_multi_if.slave bus
);

    typedef enum logic [1:0] {
        M_STRETCH = 2'b00,
        M_ONESHOT = 2'b01,
        M_BLINK   = 2'b10,
        M_OFF     = 2'b11
    } mode_e;

    localparam int unsigned   PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    if (PRESC < 1 || BLINK_HALF == 8'd0 || DURATION == '0) begin : g_param_check
        $error("ledblink_multi: PRESC, BLINK_HALF and DURATION must be non-zero");
    end

    logic [PW-1:0]  r_presc;
    logic           w_tick;
    logic [NCH-1:0] w_q;
    logic [NCH-1:0] w_active;

    // With PRESC=1 the counter sits at 0 and every cycle is a tick.
    assign w_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        mode_e           w_mode;
        logic            w_trig;
        logic [CNTW-1:0] r_cnt;
        logic [CNTW-1:0] w_cnt_nx;
        logic            r_q;
        logic            w_q_nx;
        logic            r_active;
`ifdef LEDBLINK_MULTI_BLINK_EN
        logic [7:0]      r_phase;
        logic [7:0]      w_phase_nx;
        mode_e           r_lmode;
        mode_e           w_lmode_nx;
`endif

        assign w_mode = mode_e'(bus.mode[2*i+1 -: 2]);
        assign w_trig = bus.trigger[i];

        always_comb begin
            w_cnt_nx = r_cnt;
            w_q_nx   = r_q;
`ifdef LEDBLINK_MULTI_BLINK_EN
            w_phase_nx = r_phase;
            w_lmode_nx = r_lmode;
`endif
            if (w_mode == M_OFF) begin
                w_cnt_nx = '0;
                w_q_nx   = 1'b0;
            end else if (w_trig && (r_cnt == '0)) begin
                w_cnt_nx = DURATION;
                w_q_nx   = 1'b1;
`ifdef LEDBLINK_MULTI_BLINK_EN
                w_phase_nx = BLINK_HALF;
                w_lmode_nx = w_mode;
`endif
            end else if (w_trig && (w_mode != M_ONESHOT)) begin
                // Retrigger follows the mode presented now, not the latched one.
                w_cnt_nx = DURATION;
`ifdef LEDBLINK_MULTI_BLINK_EN
                if (w_mode != M_BLINK) begin
                    w_q_nx = 1'b1;
                end
`else
                w_q_nx = 1'b1;
`endif
            end else if (w_tick && (r_cnt != '0)) begin
                w_cnt_nx = r_cnt - 1'b1;
                if (r_cnt == CNTW'(1)) begin
                    w_q_nx = 1'b0;
                end
`ifdef LEDBLINK_MULTI_BLINK_EN
                else if (r_lmode == M_BLINK) begin
                    // Expiry above wins over a toggle on the same edge.
                    if (r_phase <= 8'd1) begin
                        w_q_nx     = ~r_q;
                        w_phase_nx = BLINK_HALF;
                    end else begin
                        w_phase_nx = r_phase - 8'd1;
                    end
                end
`endif
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt    <= '0;
                r_q      <= 1'b0;
                r_active <= 1'b0;
            end else begin
                r_cnt    <= w_cnt_nx;
                r_q      <= w_q_nx;
                r_active <= (w_cnt_nx != '0);
            end
        end

`ifdef LEDBLINK_MULTI_BLINK_EN
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_phase <= 8'd0;
                r_lmode <= M_STRETCH;
            end else begin
                r_phase <= w_phase_nx;
                r_lmode <= w_lmode_nx;
            end
        end
`endif

        assign w_q[i]      = r_q;
        assign w_active[i] = r_active;
    end

    assign bus.q      = w_q;
    assign bus.active = w_active;

endmodule

// File: tb/tb_ledblink_multi.sv
// Scoreboard bench for ledblink_multi: directed steps push expected q/active, a monitor pops and compares.
module tb_ledblink_multi;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ledblink_multi_if #(.NCH(4)) bus_a ();
    ledblink_multi_if #(.NCH(4)) bus_b ();

    ledblink_multi #(
        .NCH(4), .CNTW(16), .DURATION(16'd5), .PRESC(1), .BLINK_HALF(8'd2)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );

    ledblink_multi #(
        .NCH(4), .CNTW(16), .DURATION(16'd3), .PRESC(4), .BLINK_HALF(8'd2)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b)
    );

    typedef struct {
        int         cyc;
        int         id;
        logic [3:0] q;
        logic [3:0] act;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   cyc_rel;
    int   n_cmp = 0;
    int   n_bad = 0;
    event chk_now;
    logic [5:0] bq6;
    logic [7:0] bq8;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk or chk_now) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t       e;
            logic [3:0] aq;
            logic [3:0] aa;
            e  = sb.pop_front();
            aq = (e.id == 0) ? bus_a.q : bus_b.q;
            aa = (e.id == 0) ? bus_a.active : bus_b.active;
            n_cmp++;
            if (aq !== e.q || aa !== e.act) begin
                n_bad++;
                $display("FAIL %s dut%0d cycle %0d: q=%b active=%b, expected q=%b active=%b",
                         e.name, e.id, cyc, aq, aa, e.q, e.act);
            end
        end
    end

    task automatic step(input int id, input logic [3:0] trig, input logic [7:0] md,
                        input logic [3:0] eq, input logic [3:0] ea, input string nm);
        if (id == 0) begin
            bus_a.trigger = trig;
            bus_a.mode    = md;
        end else begin
            bus_b.trigger = trig;
            bus_b.mode    = md;
        end
        sb.push_back('{cyc: cyc + 1, id: id, q: eq, act: ea, name: nm});
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int id, input logic [3:0] trig, input logic [7:0] md,
                         input logic [3:0] eq, input logic [3:0] ea, input string nm, input int n);
        for (int j = 0; j < n; j++) step(id, trig, md, eq, ea, nm);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus_a.trigger = '0;
        bus_a.mode    = '0;
        bus_b.trigger = '0;
        bus_b.mode    = '0;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back('{cyc: cyc, id: 0, q: 4'b0, act: 4'b0, name: "reset_state_a"});
        sb.push_back('{cyc: cyc, id: 1, q: 4'b0, act: 4'b0, name: "reset_state_b"});
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        steps(0, 4'b0000, 8'h00, 4'b0000, 4'b0000, "idle", 2);

        // stretch: 5 samples high, then low
        step (0, 4'b0001, 8'h00, 4'b0001, 4'b0001, "stretch_load");
        steps(0, 4'b0000, 8'h00, 4'b0001, 4'b0001, "stretch_hold", 4);
        steps(0, 4'b0000, 8'h00, 4'b0000, 4'b0000, "stretch_end", 2);

        // stretch retrigger at k+3: falls after k+8
        step (0, 4'b0001, 8'h00, 4'b0001, 4'b0001, "retrig_load");
        steps(0, 4'b0000, 8'h00, 4'b0001, 4'b0001, "retrig_hold", 2);
        step (0, 4'b0001, 8'h00, 4'b0001, 4'b0001, "retrig_again");
        steps(0, 4'b0000, 8'h00, 4'b0001, 4'b0001, "retrig_hold2", 4);
        step (0, 4'b0000, 8'h00, 4'b0000, 4'b0000, "retrig_end");

        // one-shot: second trigger ignored
        step (0, 4'b0001, 8'h01, 4'b0001, 4'b0001, "oneshot_load");
        step (0, 4'b0000, 8'h01, 4'b0001, 4'b0001, "oneshot_hold");
        step (0, 4'b0001, 8'h01, 4'b0001, 4'b0001, "oneshot_ignored");
        steps(0, 4'b0000, 8'h01, 4'b0001, 4'b0001, "oneshot_hold2", 2);
        steps(0, 4'b0000, 8'h01, 4'b0000, 4'b0000, "oneshot_end", 2);

        // one-shot held: expires at k+5, re-fires at k+6
        steps(0, 4'b0001, 8'h01, 4'b0001, 4'b0001, "oneshot_held", 5);
        step (0, 4'b0001, 8'h01, 4'b0000, 4'b0000, "oneshot_held_gap");
        step (0, 4'b0001, 8'h01, 4'b0001, 4'b0001, "oneshot_refire");
        steps(0, 4'b0000, 8'h01, 4'b0001, 4'b0001, "oneshot_refire_hold", 4);
        steps(0, 4'b0000, 8'h00, 4'b0000, 4'b0000, "oneshot_refire_end", 2);

        // blink on channel 1
`ifdef LEDBLINK_MULTI_BLINK_EN
        bq6 = 6'b110010;
        bq8 = 8'b11100110;
`else
        bq6 = 6'b111110;
        bq8 = 8'b11111110;
`endif
        for (int j = 0; j < 6; j++)
            step(0, (j == 0) ? 4'b0010 : 4'b0000, 8'h08,
                 {2'b00, bq6[5-j], 1'b0}, {2'b00, (j < 5), 1'b0}, "blink");
        step(0, 4'b0000, 8'h00, 4'b0000, 4'b0000, "blink_idle");
        for (int j = 0; j < 8; j++)
            step(0, (j == 0 || j == 2) ? 4'b0010 : 4'b0000, 8'h08,
                 {2'b00, bq8[7-j], 1'b0}, {2'b00, (j < 7), 1'b0}, "blink_retrig");
        step(0, 4'b0000, 8'h00, 4'b0000, 4'b0000, "blink_retrig_idle");

        // off on channel 2 aborts the pulse and ignores triggers
        step(0, 4'b0100, 8'h00, 4'b0100, 4'b0100, "off_load");
        step(0, 4'b0000, 8'h00, 4'b0100, 4'b0100, "off_hold");
        step(0, 4'b0000, 8'h30, 4'b0000, 4'b0000, "off_abort");
        step(0, 4'b0100, 8'h30, 4'b0000, 4'b0000, "off_ignores_trig");
        step(0, 4'b0000, 8'h00, 4'b0000, 4'b0000, "off_idle");

        // simultaneous identical pulses on 0,1,3
        step (0, 4'b1011, 8'h00, 4'b1011, 4'b1011, "multi_load");
        steps(0, 4'b0000, 8'h00, 4'b1011, 4'b1011, "multi_hold", 4);
        step (0, 4'b0000, 8'h00, 4'b0000, 4'b0000, "multi_end");

        // mixed modes: ch1 one-shot ignores retrigger, ch3 stretch reloads
        step (0, 4'b1011, 8'h04, 4'b1011, 4'b1011, "mixed_load");
        step (0, 4'b0000, 8'h04, 4'b1011, 4'b1011, "mixed_hold");
        step (0, 4'b1010, 8'h04, 4'b1011, 4'b1011, "mixed_retrig");
        steps(0, 4'b0000, 8'h04, 4'b1011, 4'b1011, "mixed_hold2", 2);
        steps(0, 4'b0000, 8'h04, 4'b1000, 4'b1000, "mixed_ch3_only", 2);
        step (0, 4'b0000, 8'h00, 4'b0000, 4'b0000, "mixed_end");

        // asynchronous reset mid-pulse
        step(0, 4'b0001, 8'h00, 4'b0001, 4'b0001, "rst_pulse_load");
        step(0, 4'b0000, 8'h00, 4'b0001, 4'b0001, "rst_pulse_hold");
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        sb.push_back('{cyc: cyc, id: 0, q: 4'b0, act: 4'b0, name: "reset_async"});
        -> chk_now;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc_rel = cyc;
        steps(0, 4'b0000, 8'h00, 4'b0000, 4'b0000, "post_reset_idle", 3);

        // prescaler: load on a tick edge gives exactly DURATION*PRESC = 12 cycles
        while (((cyc - cyc_rel) % 4) != 3) begin
            @(posedge clk);
            #1;
        end
        step (1, 4'b0001, 8'h00, 4'b0001, 4'b0001, "presc_load");
        steps(1, 4'b0000, 8'h00, 4'b0001, 4'b0001, "presc_hold", 11);
        step (1, 4'b0000, 8'h00, 4'b0000, 4'b0000, "presc_end");

        for (int j = 0; j < 5 && sb.size() > 0; j++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
